alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_ctrl_decode.sv | 44 ++++
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU control codes, opcode/funct encodings and sequencer states
package alu_ctrl_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CTRL_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] CTRL_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [CODE_W-1:0] CTRL_NOR  = 4'b1100;
  localparam logic [CODE_W-1:0] CTRL_SLL  = 4'b1101;
  localparam logic [CODE_W-1:0] CTRL_SRL  = 4'b1110;
  localparam logic [CODE_W-1:0] CTRL_MULT = 4'b1000;
  localparam logic [CODE_W-1:0] CTRL_DIV  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct to ALU control code decoder
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]        i_alu_op,
  input  logic [5:0]        i_funct,
  output logic [CODE_W-1:0] o_code,
  output logic              o_is_multi,
  output logic              o_is_illegal
);

  always_comb begin
    o_code       = CTRL_ADD;
    o_is_multi   = 1'b0;
    o_is_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_code = CTRL_ADD;
      ALUOP_BEQ: o_code = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_SLL:  o_code = CTRL_SLL;
          FUNCT_SRL:  o_code = CTRL_SRL;
          FUNCT_ADD:  o_code = CTRL_ADD;
          FUNCT_SUB:  o_code = CTRL_SUB;
          FUNCT_AND:  o_code = CTRL_AND;
          FUNCT_OR:   o_code = CTRL_OR;
          FUNCT_NOR:  o_code = CTRL_NOR;
          FUNCT_SLT:  o_code = CTRL_SLT;
          FUNCT_MULT: begin
            o_code     = CTRL_MULT;
            o_is_multi = 1'b1;
          end
          FUNCT_DIV: begin
            o_code     = CTRL_DIV;
            o_is_multi = 1'b1;
          end
          default: o_is_illegal = 1'b1;
        endcase
      end
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - accepts ALU ops, registers the control code, sequences mult/div latency
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CTRL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic [CTRL_W-1:0] control_line,
  output logic              out_valid,
  output logic              busy,
  output logic              illegal
);

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_valid;
  logic                r_illegal;

  logic [CODE_W-1:0]   w_code;
  logic                w_is_multi;
  logic                w_is_illegal;
  logic                w_accept;
  logic [3:0]          w_lat_load;

  alu_ctrl_decode u_decode (
    .i_alu_op    (ALUOp),
    .i_funct     (funct),
    .o_code      (w_code),
    .o_is_multi  (w_is_multi),
    .o_is_illegal(w_is_illegal)
  );

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  // Counter runs LAT-2 down to 0 in BUSY, then one DONE cycle: out_valid lands LAT cycles after acceptance.
  assign w_lat_load = (w_code == CTRL_DIV) ? 4'(DIV_LAT - 2) : 4'(MUL_LAT - 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && w_is_multi && !w_is_illegal) w_next_state = ST_BUSY;
        ST_BUSY: if (r_cnt == 4'd0) w_next_state = ST_DONE;
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_ctrl    <= CTRL_W'(CTRL_ADD);
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      if (flush) begin
        r_cnt <= 4'd0;
      end else if (w_accept) begin
        if (w_is_illegal) begin
          r_illegal <= 1'b1;
        end else begin
          r_ctrl <= CTRL_W'(w_code);
          if (w_is_multi) begin
            r_cnt <= w_lat_load;
          end else begin
            r_valid <= 1'b1;
          end
        end
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    in_ready     = (r_state == ST_IDLE);
    busy         = (r_state == ST_BUSY);
    out_valid    = r_valid || (r_state == ST_DONE);
    illegal      = r_illegal;
    control_line = r_ctrl;
  end

endmodule
